// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command controller:
// FSM states, frame header, command/error codes and baud table.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_EXEC
    } state_t;

    localparam int BPS_W = 20;

    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [7:0] MAX_LEN  = 8'd4;
    localparam logic [7:0] MAX_BAUD = 8'd4;

    localparam logic [7:0] CMD_BAUD = 8'h01;
    localparam logic [7:0] CMD_TRIG = 8'h02;
    localparam logic [7:0] CMD_PER  = 8'h03;
    localparam logic [7:0] CMD_STOP = 8'h04;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_CHK  = 3'd1;
    localparam logic [2:0] ERR_TMO  = 3'd2;
    localparam logic [2:0] ERR_ARG  = 3'd3;
    localparam logic [2:0] ERR_BUSY = 3'd4;

    function automatic logic [BPS_W-1:0] baud_lut(input logic [2:0] sel);
        logic [BPS_W-1:0] b;
        unique case (sel)
            3'd0:    b = 20'd9600;
            3'd1:    b = 20'd19200;
            3'd2:    b = 20'd38400;
            3'd3:    b = 20'd57600;
            default: b = 20'd115200;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/meas_scheduler.sv
// Measurement trigger: merges single triggers with a periodic
// millisecond tick that is skipped (and restarted) while busy.
module meas_scheduler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic        cfg_we,
    input  logic        cfg_en,
    input  logic [15:0] cfg_period,
    input  logic        meas_busy,
    output logic        meas_start
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int CW     = (MS_CYC > 2) ? $clog2(MS_CYC) : 1;

    logic          per_en;
    logic [15:0]   period_ms;
    logic [CW-1:0] cyc_cnt;
    logic [15:0]   ms_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_en     <= 1'b0;
            period_ms  <= 16'd0;
            cyc_cnt    <= '0;
            ms_cnt     <= 16'd0;
            meas_start <= 1'b0;
        end else begin
            meas_start <= trig;
            if (cfg_we) begin
                per_en    <= cfg_en;
                period_ms <= cfg_period;
                cyc_cnt   <= '0;
                ms_cnt    <= 16'd0;
            end else if (per_en) begin
                if (cyc_cnt == CW'(MS_CYC - 1)) begin
                    cyc_cnt <= '0;
                    // A busy tick is dropped but still restarts the period
                    if (ms_cnt == period_ms - 16'd1) begin
                        ms_cnt <= 16'd0;
                        if (!meas_busy)
                            meas_start <= 1'b1;
                    end else begin
                        ms_cnt <= ms_cnt + 16'd1;
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + CW'(1);
                end
            end else begin
                cyc_cnt <= '0;
                ms_cnt  <= 16'd0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command framer/decoder: parses A5-headed frames, checks XOR,
// owns the baud register and drives the measurement scheduler.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int RST_BPS     = 9600
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             meas_busy,
    output logic [BPS_W-1:0] rx_bps,
    output logic             meas_start,
    output logic             cmd_ok,
    output logic             err,
    output logic [2:0]       err_code
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t        state;
    logic [7:0]    cmd_r;
    logic [2:0]    len_r;
    logic [2:0]    cnt;
    logic [15:0]   pay;
    logic [7:0]    chk_acc;
    logic          chk_ok;
    logic [TW-1:0] tcnt;
    logic          tmo;

    logic             ok_n;
    logic             err_n;
    logic [2:0]       code_n;
    logic             bps_we;
    logic [BPS_W-1:0] bps_n;
    logic             trig;
    logic             cfg_we;
    logic             cfg_en;

    // A byte arriving on the expiry cycle takes priority
    assign tmo = (tcnt == TW'(TIMEOUT_CYC - 1)) && !rx_done;

    always_comb begin
        ok_n   = 1'b0;
        err_n  = 1'b0;
        code_n = ERR_NONE;
        bps_we = 1'b0;
        bps_n  = baud_lut(pay[2:0]);
        trig   = 1'b0;
        cfg_we = 1'b0;
        cfg_en = 1'b0;
        if (state == S_EXEC) begin
            if (!chk_ok) begin
                err_n  = 1'b1;
                code_n = ERR_CHK;
            end else begin
                unique case (cmd_r)
                    CMD_BAUD: begin
                        if (len_r == 3'd1 && pay[7:0] <= MAX_BAUD) begin
                            bps_we = 1'b1;
                            ok_n   = 1'b1;
                        end else begin
                            err_n  = 1'b1;
                            code_n = ERR_ARG;
                        end
                    end
                    CMD_TRIG: begin
                        if (len_r != 3'd0) begin
                            err_n  = 1'b1;
                            code_n = ERR_ARG;
                        end else if (meas_busy) begin
                            err_n  = 1'b1;
                            code_n = ERR_BUSY;
                        end else begin
                            trig = 1'b1;
                            ok_n = 1'b1;
                        end
                    end
                    CMD_PER: begin
                        if (len_r == 3'd2) begin
                            cfg_we = 1'b1;
                            cfg_en = (pay != 16'd0);
                            ok_n   = 1'b1;
                        end else begin
                            err_n  = 1'b1;
                            code_n = ERR_ARG;
                        end
                    end
                    CMD_STOP: begin
                        if (len_r == 3'd0) begin
                            cfg_we = 1'b1;
                            ok_n   = 1'b1;
                        end else begin
                            err_n  = 1'b1;
                            code_n = ERR_ARG;
                        end
                    end
                    default: begin
                        err_n  = 1'b1;
                        code_n = ERR_ARG;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd_r    <= 8'd0;
            len_r    <= 3'd0;
            cnt      <= 3'd0;
            pay      <= 16'd0;
            chk_acc  <= 8'd0;
            chk_ok   <= 1'b0;
            tcnt     <= '0;
            rx_bps   <= BPS_W'(RST_BPS);
            cmd_ok   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            cmd_ok <= 1'b0;
            err    <= 1'b0;
            if (state == S_IDLE || rx_done)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);

            unique case (state)
                S_IDLE: begin
                    if (rx_done && rx_data == HDR)
                        state <= S_CMD;
                end
                S_CMD, S_LEN, S_PAYLOAD, S_CHK: begin
                    if (tmo) begin
                        err      <= 1'b1;
                        err_code <= ERR_TMO;
                        state    <= S_IDLE;
                    end else if (rx_done) begin
                        unique case (state)
                            S_CMD: begin
                                cmd_r   <= rx_data;
                                chk_acc <= rx_data;
                                state   <= S_LEN;
                            end
                            S_LEN: begin
                                if (rx_data > MAX_LEN) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_ARG;
                                    state    <= S_IDLE;
                                end else begin
                                    len_r   <= rx_data[2:0];
                                    cnt     <= 3'd0;
                                    pay     <= 16'd0;
                                    chk_acc <= chk_acc ^ rx_data;
                                    state   <= (rx_data == 8'd0)
                                             ? S_CHK : S_PAYLOAD;
                                end
                            end
                            S_PAYLOAD: begin
                                pay     <= {pay[7:0], rx_data};
                                chk_acc <= chk_acc ^ rx_data;
                                cnt     <= cnt + 3'd1;
                                if (cnt == len_r - 3'd1)
                                    state <= S_CHK;
                            end
                            default: begin
                                chk_ok <= (chk_acc == rx_data);
                                state  <= S_EXEC;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    cmd_ok <= ok_n;
                    err    <= err_n;
                    if (err_n)
                        err_code <= code_n;
                    if (bps_we)
                        rx_bps <= bps_n;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    meas_scheduler #(
        .CLK_HZ(CLK_HZ)
    ) u_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .cfg_we    (cfg_we),
        .cfg_en    (cfg_en),
        .cfg_period(pay),
        .meas_busy (meas_busy),
        .meas_start(meas_start)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame table with a strobe scoreboard,
// plus hand sequences for latency, timeout, periodic mode and reset.
module tb_uart_cmd_ctrl;

    localparam int CLK_HZ = 100_000;
    localparam int TMO    = 200;
    localparam int MS     = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        meas_busy;
    logic [19:0] rx_bps;
    logic        meas_start;
    logic        cmd_ok;
    logic        err;
    logic [2:0]  err_code;

    uart_cmd_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_CYC(TMO),
        .RST_BPS    (9600)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .meas_busy (meas_busy),
        .rx_bps    (rx_bps),
        .meas_start(meas_start),
        .cmd_ok    (cmd_ok),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic        e;
        logic [2:0]  code;
        logic [19:0] bps;
        logic        ms;
    } exp_t;

    typedef struct {
        logic [47:0] fr;
        int          n;
        logic        busy;
        exp_t        x;
    } vec_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;
    int   pulse_cnt = 0;
    int   last_pulse = 0;
    int   strobe_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic ok, input logic e,
                                input logic [2:0] code,
                                input logic [19:0] bps, input logic ms);
        exp_t x;
        x.ok = ok; x.e = e; x.code = code; x.bps = bps; x.ms = ms;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        cyc_n++;
        if (meas_start) begin
            pulse_cnt++;
            last_pulse = cyc_n;
        end
        if (cmd_ok || err) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                x = exp_q.pop_front();
                check("cmd_ok", int'(cmd_ok), int'(x.ok));
                check("err", int'(err), int'(x.e));
                if (x.e)
                    check("err_code", int'(err_code), int'(x.code));
                check("rx_bps", int'(rx_bps), int'(x.bps));
                check("meas_start", int'(meas_start), int'(x.ms));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] fr, input int n);
        for (int i = 0; i < n; i++)
            send_byte(fr[47-8*i -: 8]);
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_pulse(input int bound, output int t);
        int c0 = pulse_cnt;
        int c = 0;
        t = 0;
        while (pulse_cnt == c0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        if (pulse_cnt == c0)
            check("pulse_timeout", 0, 1);
        else
            t = last_pulse;
    endtask

    vec_t vecs[10];

    initial begin
        int t1, t2, t3, c, s0, p0;
        #2000000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, c, s0, p0;

        vecs[0] = '{48'hA5_01_01_01_01_00, 5, 1'b0, mk(1, 0, 0, 19200, 0)};
        vecs[1] = '{48'hA5_02_00_02_00_00, 4, 1'b0, mk(1, 0, 0, 19200, 1)};
        vecs[2] = '{48'hA5_02_00_02_00_00, 4, 1'b1, mk(0, 1, 4, 19200, 0)};
        vecs[3] = '{48'hA5_01_01_07_FF_00, 5, 1'b0, mk(0, 1, 1, 19200, 0)};
        vecs[4] = '{48'hA5_01_01_04_04_00, 5, 1'b0, mk(1, 0, 0, 115200, 0)};
        vecs[5] = '{48'hA5_01_01_05_05_00, 5, 1'b0, mk(0, 1, 3, 115200, 0)};
        vecs[6] = '{48'hA5_07_00_07_00_00, 4, 1'b0, mk(0, 1, 3, 115200, 0)};
        vecs[7] = '{48'hA5_02_01_00_03_00, 5, 1'b0, mk(0, 1, 3, 115200, 0)};
        vecs[8] = '{48'h33_A5_01_01_00_00, 6, 1'b0, mk(1, 0, 0, 9600, 0)};
        vecs[9] = '{48'hA5_01_05_00_00_00, 3, 1'b0, mk(0, 1, 3, 9600, 0)};

        rst_n = 1'b0;
        rx_data = 8'd0;
        rx_done = 1'b0;
        meas_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bps", int'(rx_bps), 9600);
        check("rst_strobes", int'({meas_start, cmd_ok, err}), 0);
        check("rst_code", int'(err_code), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            meas_busy = vecs[i].busy;
            exp_q.push_back(vecs[i].x);
            send_frame(vecs[i].fr, vecs[i].n);
            drain("vec_drain");
            meas_busy = 1'b0;
        end

        // CHK in cycle T: quiet in T+1, strobe in T+2
        exp_q.push_back(mk(1, 0, 0, 9600, 1));
        send_frame(48'hA5_02_00_00_00_00, 3);
        send_byte(8'h02);
        check("lat_t1", int'({cmd_ok, err, meas_start}), 0);
        @(negedge clk);
        check("lat_t2", int'({cmd_ok, meas_start}), 3);
        drain("lat_drain");

        // LEN error lands one cycle after its byte
        exp_q.push_back(mk(0, 1, 3, 9600, 0));
        send_frame(48'hA5_01_08_00_00_00, 3);
        check("len_err_lat", int'(err), 1);
        drain("len_drain");

        // rx_done during EXEC is dropped
        s0 = strobe_cnt;
        exp_q.push_back(mk(1, 0, 0, 9600, 0));
        send_frame(48'hA5_04_00_04_00_00, 4);
        rx_data = 8'hA5;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        send_frame(48'h02_00_02_00_00_00, 3);
        repeat (20) @(negedge clk);
        check("exec_discard", strobe_cnt - s0, 1);
        drain("exec_drain");

        // inter-byte timeout
        exp_q.push_back(mk(0, 1, 2, 9600, 0));
        send_frame(48'hA5_03_00_00_00_00, 2);
        c = 0;
        while (!err && c < TMO + 50) begin
            @(negedge clk);
            c++;
        end
        check("tmo_latency", c, TMO);
        drain("tmo_drain");
        exp_q.push_back(mk(1, 0, 0, 9600, 1));
        send_frame(48'hA5_02_00_02_00_00, 4);
        drain("post_tmo");

        // periodic mode, 3 ms
        exp_q.push_back(mk(1, 0, 0, 9600, 0));
        send_frame(48'hA5_03_02_00_03_02, 6);
        drain("per_drain");
        wait_pulse(4 * MS + 50, t1);
        wait_pulse(4 * MS + 50, t2);
        check("period_3ms", t2 - t1, 3 * MS);
        repeat (150) @(negedge clk);
        meas_busy = 1'b1;
        p0 = pulse_cnt;
        repeat (3 * MS) @(negedge clk);
        check("busy_skip", pulse_cnt - p0, 0);
        meas_busy = 1'b0;
        wait_pulse(4 * MS + 50, t3);
        check("skip_restart", t3 - t2, 6 * MS);
        exp_q.push_back(mk(1, 0, 0, 9600, 0));
        send_frame(48'hA5_04_00_04_00_00, 4);
        drain("stop_drain");
        p0 = pulse_cnt;
        repeat (7 * MS) @(negedge clk);
        check("stopped", pulse_cnt - p0, 0);

        // reset mid-payload with periodic running and baud changed
        exp_q.push_back(mk(1, 0, 0, 115200, 0));
        send_frame(48'hA5_01_01_04_04_00, 5);
        drain("pre_rst_baud");
        exp_q.push_back(mk(1, 0, 0, 115200, 0));
        send_frame(48'hA5_03_02_00_01_00, 6);
        drain("pre_rst_per");
        send_frame(48'hA5_03_02_00_00_00, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bps", int'(rx_bps), 9600);
        check("mid_rst_out", int'({meas_start, cmd_ok, err, err_code}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        p0 = pulse_cnt;
        send_frame(48'h00_01_00_00_00_00, 2);
        repeat (3 * MS) @(negedge clk);
        check("post_rst_strobe", strobe_cnt - s0, 0);
        check("post_rst_pulse", pulse_cnt - p0, 0);
        check("post_rst_bps", int'(rx_bps), 9600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
